sr_bank_arbiter: RTL and testbench

Sequencer and two-port arbiter for a bank of master-slave SR flip-flops. Two requesters each ask to set or reset one bit of the bank. The block grants them round-robin and drives one-hot S/R pulses of fixed length, never S and R together, then a quiet settle window. It acknowledges completion and can optionally verify the bit by readback.

---
 rtl/sr_bank_pkg.sv | 19 +
 rtl/sr_bank_arbiter_rr_arb2.sv | 37 +++
 rtl/sr_bank_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_sr_bank_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sr_bank_pkg.sv
// Shared types for the SR flip-flop bank sequencer: FSM state encoding,
// operation codes and a small constant helper.
package sr_bank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_DONE   = 2'd3
   } st_e;

   localparam logic OP_RESET = 1'b0;
   localparam logic OP_SET   = 1'b1;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sr_bank_arbiter_rr_arb2.sv
// Two-request round-robin picker. The last-grant register resets to port 1
// so that port 0 wins the first contention.
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst_l,
   input  logic [1:0] i_req,
   input  logic       i_take,
   output logic       o_gnt,
   output logic       o_valid
);

   logic r_last;

   // Pick the requester that was not granted last when both are asking.
   always_comb begin
      o_valid = i_req[0] | i_req[1];
      if (i_req[0] && i_req[1]) begin
         o_gnt = ~r_last;
      end else if (i_req[1]) begin
         o_gnt = 1'b1;
      end else begin
         o_gnt = 1'b0;
      end
   end

   // Remember the winner whenever the grant is actually consumed.
   always_ff @(posedge i_clk or negedge i_rst_l) begin
      if (!i_rst_l) begin
         r_last <= 1'b1;
      end else if (i_take) begin
         r_last <= o_gnt;
      end else begin
         r_last <= r_last;
      end
   end

endmodule

// File: rtl/sr_bank_arbiter.sv
// Arbiter and pulse sequencer for a bank of SR flip-flops (IDLE/DRIVE/SETTLE/DONE).
// Optional readback of the target bit is enabled by SR_BANK_ARBITER_READBACK_EN.
module sr_bank_arbiter
   import sr_bank_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int IDX_W      = 3,
   parameter int DRIVE_CYC  = 2,
   parameter int SETTLE_CYC = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_l,
   input  logic             i_req0,
   input  logic             i_req1,
   input  logic             i_op0,
   input  logic             i_op1,
   input  logic [IDX_W-1:0] i_idx0,
   input  logic [IDX_W-1:0] i_idx1,
   input  logic [WIDTH-1:0] i_q_in,
   output logic             o_ack0,
   output logic             o_ack1,
   output logic [WIDTH-1:0] o_s,
   output logic [WIDTH-1:0] o_r,
   output logic             o_busy,
   output logic             o_err
);

   localparam int             CNT_W   = $clog2(max2(DRIVE_CYC, SETTLE_CYC) + 1);
   localparam logic [IDX_W:0] IDX_LIM = (IDX_W + 1)'(WIDTH);

   st_e              r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_op, w_op_nxt;
   logic             r_port, w_port_nxt;
   logic             r_bad, w_bad_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt;

   logic             w_gnt, w_valid, w_take;
   logic             w_sel_op, w_sel_bad, w_rb_fail;
   logic [IDX_W-1:0] w_sel_idx;

   logic [WIDTH-1:0] r_s, r_r, w_s_nxt, w_r_nxt;
   logic             r_ack0, r_ack1, r_busy, r_err;
   logic             w_ack0_nxt, w_ack1_nxt, w_busy_nxt, w_err_nxt;

   rr_arb2 u_arb (
      .i_clk   (i_clk),
      .i_rst_l (i_rst_l),
      .i_req   ({i_req1, i_req0}),
      .i_take  (w_take),
      .o_gnt   (w_gnt),
      .o_valid (w_valid)
   );

   assign w_take = (r_state == ST_IDLE) && w_valid;

   // Steer the winning port's command fields and flag out-of-range targets.
   always_comb begin
      w_sel_op  = w_gnt ? i_op1  : i_op0;
      w_sel_idx = w_gnt ? i_idx1 : i_idx0;
      w_sel_bad = ({1'b0, w_sel_idx} >= IDX_LIM);
   end

`ifdef SR_BANK_ARBITER_READBACK_EN
   assign w_rb_fail = (i_q_in[r_idx] != r_op);
`else
   logic w_unused_q;
   assign w_unused_q = ^i_q_in;
   assign w_rb_fail  = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_l) begin
      if (!i_rst_l) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a zero-length settle window goes straight to DONE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_valid) begin
               w_state_nxt = w_sel_bad ? ST_DONE : ST_DRIVE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (r_cnt != CNT_W'(0)) begin
               w_state_nxt = ST_DRIVE;
            end else if (SETTLE_CYC == 0) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (r_cnt != CNT_W'(0)) begin
               w_state_nxt = ST_SETTLE;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Command latch and dwell counter; the counter reloads on each state entry.
   always_comb begin
      if (w_take) begin
         w_op_nxt   = w_sel_op;
         w_idx_nxt  = w_sel_idx;
         w_port_nxt = w_gnt;
         w_bad_nxt  = w_sel_bad;
      end else begin
         w_op_nxt   = r_op;
         w_idx_nxt  = r_idx;
         w_port_nxt = r_port;
         w_bad_nxt  = r_bad;
      end
      if (w_state_nxt != r_state) begin
         case (w_state_nxt)
            ST_DRIVE:  w_cnt_nxt = CNT_W'(DRIVE_CYC - 1);
            ST_SETTLE: w_cnt_nxt = CNT_W'(SETTLE_CYC - 1);
            default:   w_cnt_nxt = CNT_W'(0);
         endcase
      end else if (r_cnt != CNT_W'(0)) begin
         w_cnt_nxt = r_cnt - CNT_W'(1);
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   // Output decode from the upcoming state so every output is a flop.
   always_comb begin
      w_s_nxt = {WIDTH{1'b0}};
      w_r_nxt = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         if ((w_state_nxt == ST_DRIVE) && (w_idx_nxt == IDX_W'(i))) begin
            w_s_nxt[i] = (w_op_nxt == OP_SET);
            w_r_nxt[i] = (w_op_nxt == OP_RESET);
         end else begin
            w_s_nxt[i] = 1'b0;
            w_r_nxt[i] = 1'b0;
         end
      end
      w_busy_nxt = (w_state_nxt != ST_IDLE);
      if (w_state_nxt == ST_DONE) begin
         w_ack0_nxt = ~w_port_nxt;
         w_ack1_nxt = w_port_nxt;
         w_err_nxt  = w_bad_nxt | w_rb_fail;
      end else begin
         w_ack0_nxt = 1'b0;
         w_ack1_nxt = 1'b0;
         w_err_nxt  = 1'b0;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge i_clk or negedge i_rst_l) begin
      if (!i_rst_l) begin
         r_cnt  <= CNT_W'(0);
         r_op   <= OP_RESET;
         r_idx  <= {IDX_W{1'b0}};
         r_port <= 1'b0;
         r_bad  <= 1'b0;
         r_s    <= {WIDTH{1'b0}};
         r_r    <= {WIDTH{1'b0}};
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         r_busy <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_op   <= w_op_nxt;
         r_idx  <= w_idx_nxt;
         r_port <= w_port_nxt;
         r_bad  <= w_bad_nxt;
         r_s    <= w_s_nxt;
         r_r    <= w_r_nxt;
         r_ack0 <= w_ack0_nxt;
         r_ack1 <= w_ack1_nxt;
         r_busy <= w_busy_nxt;
         r_err  <= w_err_nxt;
      end
   end

   assign o_s    = r_s;
   assign o_r    = r_r;
   assign o_ack0 = r_ack0;
   assign o_ack1 = r_ack1;
   assign o_busy = r_busy;
   assign o_err  = r_err;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed bench for sr_bank_arbiter: default 8-bit bank plus a 6-bit bank
// instance for illegal-index cases, with a behavioural bank model and invariants.
module tb_sr_bank_arbiter;

`ifdef SR_BANK_ARBITER_READBACK_EN
   localparam logic RB = 1'b1;
`else
   localparam logic RB = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_l;
   logic       req0, req1, op0, op1;
   logic [2:0] idx0, idx1;
   logic [7:0] q_in  = 8'h00;
   logic [7:0] stuck = 8'h00;
   logic       ack0, ack1, busy, err;
   logic [7:0] s, r;

   logic       req6_0, req6_1, op6_0, op6_1;
   logic [2:0] idx6_0, idx6_1;
   logic [5:0] q6 = 6'h00;
   logic       ack6_0, ack6_1, busy6, err6;
   logic [5:0] s6, r6;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sr_bank_arbiter u_dut (
      .i_clk(clk), .i_rst_l(rst_l),
      .i_req0(req0), .i_req1(req1), .i_op0(op0), .i_op1(op1),
      .i_idx0(idx0), .i_idx1(idx1), .i_q_in(q_in),
      .o_ack0(ack0), .o_ack1(ack1), .o_s(s), .o_r(r), .o_busy(busy), .o_err(err)
   );

   sr_bank_arbiter #(.WIDTH(6), .IDX_W(3), .DRIVE_CYC(2), .SETTLE_CYC(1)) u_dut6 (
      .i_clk(clk), .i_rst_l(rst_l),
      .i_req0(req6_0), .i_req1(req6_1), .i_op0(op6_0), .i_op1(op6_1),
      .i_idx0(idx6_0), .i_idx1(idx6_1), .i_q_in(q6),
      .o_ack0(ack6_0), .o_ack1(ack6_1), .o_s(s6), .o_r(r6), .o_busy(busy6), .o_err(err6)
   );

   // Behavioural bank: S sets, R clears, stuck bits read back as zero.
   always @(posedge clk) q_in <= ((q_in | s) & ~r) & ~stuck;

   // Invariants on the 8-bit instance, every cycle.
   always @(negedge clk) begin
      checks++;
      assert (((s & r) == 8'h00) && ($countones(s | r) <= 1) && !(ack0 && ack1) &&
              ((stuck != 8'h00) || (err === 1'b0)))
      else begin
         errors++;
         $error("FAIL invariant observed s=%h r=%h ack0=%b ack1=%b err=%b expected disjoint one-hot drive, single ack, err=0",
                s, r, ack0, ack1, err);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [7:0] es, input logic [7:0] er,
                      input logic ea0, input logic ea1, input logic eb, input logic ee);
      logic [19:0] o, e;
      o = {s, r, ack0, ack1, busy, err};
      e = {es, er, ea0, ea1, eb, ee};
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed {s,r,a0,a1,busy,err}=%05h expected %05h", tag, o, e);
      end
   endtask

   task automatic chk6(input string tag, input logic [5:0] es, input logic [5:0] er,
                       input logic ea0, input logic ea1, input logic eb, input logic ee);
      logic [15:0] o, e;
      o = {s6, r6, ack6_0, ack6_1, busy6, err6};
      e = {es, er, ea0, ea1, eb, ee};
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed {s,r,a0,a1,busy,err}=%04h expected %04h", tag, o, e);
      end
   endtask

   initial begin
      rst_l = 1'b0;
      req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0; idx0 = 3'd0; idx1 = 3'd0;
      req6_0 = 1'b0; req6_1 = 1'b0; op6_0 = 1'b0; op6_1 = 1'b0; idx6_0 = 3'd0; idx6_1 = 3'd0;
      ticks(2);
      chk("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk6("reset6", 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Contention straight out of reset: port 0 first, port 1 next.
      req0 = 1'b1; op0 = 1'b1; idx0 = 3'd1;
      req1 = 1'b1; op1 = 1'b0; idx1 = 3'd5;
      rst_l = 1'b1;
      tick(); chk("cont_p0_drive1", 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(); chk("cont_p0_drive2", 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(); chk("cont_p0_settle", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(); chk("cont_p0_ack",    8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(); chk("cont_idle",      8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); chk("cont_p1_drive",  8'h00, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks(3); chk("cont_p1_ack",  8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      req1 = 1'b0;
      tick(); chk("held_idle",      8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); chk("held_p0_drive",  8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks(3); chk("held_p0_ack",  8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

      // Next simultaneous pair after a port-0 grant: port 1 first.
      op0 = 1'b1; idx0 = 3'd0;
      req1 = 1'b1; op1 = 1'b1; idx1 = 3'd6;
      tick(); chk("pair2_idle",     8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); chk("pair2_p1_drive", 8'h40, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks(3); chk("pair2_p1_ack", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      req1 = 1'b0;
      tick();
      tick(); chk("pair2_p0_drive", 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks(3); chk("pair2_p0_ack", 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      req0 = 1'b0;
      tick(); chk("pair2_idle_end", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Single set of bit 3.
      req0 = 1'b1; op0 = 1'b1; idx0 = 3'd3;
      tick(); chk("set_drive1", 8'h08, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(); chk("set_drive2", 8'h08, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(); chk("set_settle", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(); chk("set_ack",    8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      req0 = 1'b0;
      tick(); chk("set_idle",   8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset during the first drive cycle, then a clean retry.
      req0 = 1'b1; op0 = 1'b0; idx0 = 3'd4;
      tick(); chk("rst_pre_drive", 8'h00, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
      #2 rst_l = 1'b0;
      #1 chk("rst_async",          8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); chk("rst_held",      8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_l = 1'b1;
      tick(); chk("retry_drive",   8'h00, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks(3); chk("retry_ack",   8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      req0 = 1'b0;
      tick();

      // Illegal indices on the 6-bit bank, plus the highest legal index.
      req6_1 = 1'b1; op6_1 = 1'b1; idx6_1 = 3'd7;
      tick(); chk6("ill7_ack", 6'h00, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1);
      req6_1 = 1'b0;
      tick(); chk6("ill7_idle", 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      req6_0 = 1'b1; op6_0 = 1'b1; idx6_0 = 3'd6;
      tick(); chk6("ill6_ack", 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      req6_0 = 1'b0;
      tick();
      req6_0 = 1'b1; op6_0 = 1'b0; idx6_0 = 3'd5;
      tick(); chk6("legal5_drive", 6'h00, 6'h20, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks(3); chk6("legal5_ack", 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      req6_0 = 1'b0;
      tick();

      // Readback with bit 2 stuck low, then with a healthy bank.
      stuck = 8'h04;
      req0 = 1'b1; op0 = 1'b1; idx0 = 3'd2;
      tick(); chk("rb_stuck_drive", 8'h04, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks(3); chk("rb_stuck_ack", 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, RB);
      req0 = 1'b0;
      tick();
      stuck = 8'h00;
      req0 = 1'b1;
      ticks(4); chk("rb_good_ack",  8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      req0 = 1'b0;
      tick();

      // Random protocol-respecting traffic, watched by the invariant monitor.
      for (int c = 0; c < 300; c++) begin
         if (ack0) req0 = 1'b0;
         else if (!req0 && ($urandom_range(0, 1) == 1)) begin
            req0 = 1'b1; op0 = 1'($urandom_range(0, 1)); idx0 = 3'($urandom_range(0, 7));
         end
         if (ack1) req1 = 1'b0;
         else if (!req1 && ($urandom_range(0, 1) == 1)) begin
            req1 = 1'b1; op1 = 1'($urandom_range(0, 1)); idx1 = 3'($urandom_range(0, 7));
         end
         tick();
      end
      for (int c = 0; c < 30; c++) begin
         if (ack0) req0 = 1'b0;
         if (ack1) req1 = 1'b0;
         tick();
      end
      chk("drain_idle", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
